// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, runs req/ack fetches and presents instr/pc/pc+4 to decode.
// Optional PC_ALIGN_EXC_EN: misaligned jr targets trap to EXC_VECTOR and pulse align_exc.
module pc_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_offset,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4
`ifdef PC_ALIGN_EXC_EN
   ,
   output logic        align_exc
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_VALID = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        if_valid_q, if_valid_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
   logic        redir_pend_q, redir_pend_d;
   logic [31:0] redir_tgt_q, redir_tgt_d;
   logic        align_exc_q, align_exc_d;

   logic        redir;
   logic        jr_misaligned;
   logic [31:0] target;

   always_comb begin
      redir = jr | jump | br_taken;
`ifdef PC_ALIGN_EXC_EN
      jr_misaligned = jr && (jr_target[1:0] != 2'b00);
`else
      jr_misaligned = 1'b0;
`endif
      // Priority jr > jump > branch; all targets are relative to the IF slot.
      if (jr_misaligned)
         target = EXC_VECTOR;
      else if (jr)
         target = jr_target & 32'hFFFF_FFFC;
      else if (jump)
         target = {if_pc_plus4_q[31:28], jump_index, 2'b00};
      else
         target = if_pc_plus4_q + br_offset;
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_valid_d    = if_valid_q;
      if_instr_d    = if_instr_q;
      if_pc_d       = if_pc_q;
      if_pc_plus4_d = if_pc_plus4_q;
      redir_pend_d  = redir_pend_q;
      redir_tgt_d   = redir_tgt_q;
      align_exc_d   = jr_misaligned;

      unique case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (redir) pc_d = target;
         end
         S_REQ: begin
            if (imem_ack) begin
               // A redirect arriving with the ack beats any older pending target.
               if (redir) begin
                  pc_d         = target;
                  redir_pend_d = 1'b0;
               end else if (redir_pend_q) begin
                  pc_d         = redir_tgt_q;
                  redir_pend_d = 1'b0;
               end else begin
                  if_instr_d    = imem_rdata;
                  if_pc_d       = pc_q;
                  if_pc_plus4_d = pc_q + 32'd4;
                  if_valid_d    = 1'b1;
                  pc_d          = pc_q + 32'd4;
                  state_d       = S_VALID;
               end
            end else if (redir) begin
               redir_pend_d = 1'b1;
               redir_tgt_d  = target;
            end
         end
         S_VALID: begin
            if (redir) begin
               if_valid_d = 1'b0;
               pc_d       = target;
               state_d    = S_REQ;
            end else if (!stall) begin
               if_valid_d = 1'b0;
               state_d    = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         if_valid_q    <= 1'b0;
         if_instr_q    <= '0;
         if_pc_q       <= RESET_PC;
         if_pc_plus4_q <= RESET_PC + 32'd4;
         redir_pend_q  <= 1'b0;
         redir_tgt_q   <= '0;
         align_exc_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_valid_q    <= if_valid_d;
         if_instr_q    <= if_instr_d;
         if_pc_q       <= if_pc_d;
         if_pc_plus4_q <= if_pc_plus4_d;
         redir_pend_q  <= redir_pend_d;
         redir_tgt_q   <= redir_tgt_d;
         align_exc_q   <= align_exc_d;
      end
   end

   assign imem_req    = (state_q == S_REQ);
   assign imem_addr   = pc_q;
   assign if_valid    = if_valid_q;
   assign if_instr    = if_instr_q;
   assign if_pc       = if_pc_q;
   assign if_pc_plus4 = if_pc_plus4_q;
`ifdef PC_ALIGN_EXC_EN
   assign align_exc   = align_exc_q;
`else
   logic unused_align;
   assign unused_align = align_exc_q;
`endif

endmodule
